// File: rtl/uart_echo_pkg.sv
// Shared types and constants for the UART echo path.
package uart_echo_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        SEND_LF
    } echo_state_e;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // Occupancy counter width able to hold 0..depth inclusive.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; a write into a full FIFO is accepted when a read
// happens in the same cycle.
module sync_fifo
    import uart_echo_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                            CLK,
    input  logic                            rst_n,
    input  logic                            wr_en,
    input  logic [WIDTH-1:0]                wr_data,
    input  logic                            rd_en,
    output logic [WIDTH-1:0]                rd_data,
    output logic                            full,
    output logic                            empty,
    output logic [count_width(DEPTH)-1:0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = count_width(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_rd   = rd_en & ~empty;
    assign do_wr   = wr_en & (~full | do_rd);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_echo_buffer.sv
// Buffers received bytes for echo with optional CR->CR LF expansion, keeps a
// receive history vector and a sticky overflow flag.
module uart_echo_buffer
    import uart_echo_pkg::*;
#(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned HIST_BYTES = 4
) (
    input  logic                            CLK,
    input  logic                            rst_n,
    input  logic [7:0]                      rx_data,
    input  logic                            rx_valid,
    input  logic                            echo_en,
    input  logic                            crlf_en,
    output logic [7:0]                      tx_data,
    output logic                            tx_valid,
    input  logic                            tx_ready,
    output logic [HIST_BYTES*8-1:0]         history,
    output logic [count_width(DEPTH)-1:0]   fifo_count,
    output logic                            overflow,
    input  logic                            clr_overflow
);

    echo_state_e state, state_n;
    logic [7:0]  tx_data_n;
    logic        tx_valid_n;
    logic        lf_pend, lf_pend_n;
    logic        pop;
    logic        load;
    logic        hs;
    logic        push;
    logic        drop;
    logic [7:0]  head;
    logic        full;
    logic        empty;

    assign hs   = tx_valid & tx_ready;
    assign push = rx_valid & echo_en & (~full | pop);
    assign drop = rx_valid & echo_en & full & ~pop;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data (rx_data),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (fifo_count)
    );

    generate
        if (HIST_BYTES == 1) begin : g_hist_one
            always_ff @(posedge CLK or negedge rst_n) begin
                if (!rst_n) begin
                    history <= '0;
                end else if (rx_valid) begin
                    history <= rx_data;
                end
            end
        end else begin : g_hist_many
            always_ff @(posedge CLK or negedge rst_n) begin
                if (!rst_n) begin
                    history <= '0;
                end else if (rx_valid) begin
                    history <= {history[HIST_BYTES*8-9:0], rx_data};
                end
            end
        end
    endgenerate

    // A drop in the same cycle as a clear leaves the flag set.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            lf_pend  <= 1'b0;
        end else begin
            state    <= state_n;
            tx_data  <= tx_data_n;
            tx_valid <= tx_valid_n;
            lf_pend  <= lf_pend_n;
        end
    end

    always_comb begin
        state_n    = state;
        tx_data_n  = tx_data;
        tx_valid_n = tx_valid;
        lf_pend_n  = lf_pend;
        load       = 1'b0;
        case (state)
            IDLE: begin
                load = ~empty;
            end
            SEND: begin
                if (hs) begin
                    if (lf_pend) begin
                        tx_data_n = ASCII_LF;
                        lf_pend_n = 1'b0;
                        state_n   = SEND_LF;
                    end else if (!empty) begin
                        load = 1'b1;
                    end else begin
                        tx_valid_n = 1'b0;
                        state_n    = IDLE;
                    end
                end
            end
            SEND_LF: begin
                if (hs) begin
                    if (!empty) begin
                        load = 1'b1;
                    end else begin
                        tx_valid_n = 1'b0;
                        state_n    = IDLE;
                    end
                end
            end
            default: begin
                tx_valid_n = 1'b0;
                lf_pend_n  = 1'b0;
                state_n    = IDLE;
            end
        endcase
        // Loading the head is also the only point at which the FIFO pops.
        if (load) begin
            tx_data_n  = head;
            tx_valid_n = 1'b1;
            lf_pend_n  = (head == ASCII_CR) & crlf_en;
            state_n    = SEND;
        end
        pop = load;
    end

endmodule

// File: tb/tb_uart_echo_buffer.sv
// Directed bench for uart_echo_buffer with a queue-based reference model checked every cycle.
module tb_uart_echo_buffer;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned HB    = 4;

    logic              CLK = 1'b0;
    logic              rst_n = 1'b0;
    logic [7:0]        rx_data = '0;
    logic              rx_valid = 1'b0;
    logic              echo_en = 1'b0;
    logic              crlf_en = 1'b0;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready = 1'b0;
    logic [HB*8-1:0]   history;
    logic [4:0]        fifo_count;
    logic              overflow;
    logic              clr_overflow = 1'b0;

    int unsigned checks = 0;
    int unsigned errors = 0;

    uart_echo_buffer #(
        .DEPTH      (DEPTH),
        .HIST_BYTES (HB)
    ) dut (
        .CLK          (CLK),
        .rst_n        (rst_n),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .echo_en      (echo_en),
        .crlf_en      (crlf_en),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .history      (history),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: bytes waiting in the FIFO, and the output slots still owed
    // for the byte last taken from it (the byte itself plus an optional LF).
    logic [7:0]      q[$];
    logic [7:0]      slots[$];
    logic [HB*8-1:0] m_hist;
    logic            m_ovf;
    logic [7:0]      seen[$];

    always @(posedge CLK or negedge rst_n) begin
        logic [7:0] b;
        logic was_full, popped;
        if (!rst_n) begin
            q.delete();
            slots.delete();
            m_hist = '0;
            m_ovf  = 1'b0;
        end else begin
            was_full = (q.size() == DEPTH);
            popped   = 1'b0;
            if (slots.size() != 0 && tx_ready) void'(slots.pop_front());
            if (slots.size() == 0 && q.size() != 0) begin
                b = q.pop_front();
                slots.push_back(b);
                if (b == 8'h0D && crlf_en) slots.push_back(8'h0A);
                popped = 1'b1;
            end
            if (rx_valid) begin
                m_hist = {m_hist[HB*8-9:0], rx_data};
                if (echo_en) begin
                    if (!was_full || popped) q.push_back(rx_data);
                    else m_ovf = 1'b1;
                end else if (clr_overflow) m_ovf = 1'b0;
                if (echo_en && clr_overflow && (!was_full || popped)) m_ovf = 1'b0;
            end else if (clr_overflow) begin
                m_ovf = 1'b0;
            end
        end
    end

    always @(negedge CLK) begin
        chk("tx_valid", 32'(tx_valid), 32'(slots.size() != 0));
        if (slots.size() != 0) chk("tx_data", 32'(tx_data), 32'(slots[0]));
        chk("history", history, m_hist);
        chk("fifo_count", 32'(fifo_count), 32'(q.size()));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        if (rst_n && tx_valid && tx_ready) seen.push_back(tx_data);
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int unsigned n;
        n = 0;
        repeat (2) tick();
        while (!(tx_valid == 1'b0 && fifo_count == '0) && n < 200) begin
            tick();
            n++;
        end
        chk("drain_timeout", 32'(n < 200), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'h00);
        chk("rst_history", history, 32'h0);
        chk("rst_fifo_count", 32'(fifo_count), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        rst_n   = 1'b1;
        echo_en = 1'b1;
        tick();

        // Single echo: history at N+1, output at N+2, then idle.
        tx_ready = 1'b1;
        send(8'h41);
        chk("single_hist", 32'(history[7:0]), 32'h41);
        chk("single_n1_valid", 32'(tx_valid), 32'd0);
        tick();
        chk("single_n2_valid", 32'(tx_valid), 32'd1);
        chk("single_n2_data", 32'(tx_data), 32'h41);
        tick();
        chk("single_after_valid", 32'(tx_valid), 32'd0);

        // Back-to-back receive under backpressure, then drain with no bubble.
        tx_ready = 1'b0;
        rx_valid = 1'b1;
        rx_data = 8'h31; tick();
        rx_data = 8'h32; tick();
        rx_data = 8'h33; tick();
        rx_valid = 1'b0;
        repeat (10) tick();
        chk("b2b_count", 32'(fifo_count), 32'd2);
        chk("b2b_hold_data", 32'(tx_data), 32'h31);
        chk("b2b_hold_valid", 32'(tx_valid), 32'd1);
        chk("b2b_hist", 32'(history[23:0]), 32'h313233);
        tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("b2b_out_valid", 32'(tx_valid), 32'd1);
            chk("b2b_out_data", 32'(tx_data), 32'(8'h31 + i));
            tick();
        end
        chk("b2b_end_valid", 32'(tx_valid), 32'd0);

        // CR expansion on, then off.
        crlf_en = 1'b1;
        seen.delete();
        send(8'h0D);
        send(8'h58);
        wait_idle();
        chk("crlf_on_len", seen.size(), 32'd3);
        if (seen.size() == 3) begin
            chk("crlf_on_0", 32'(seen[0]), 32'h0D);
            chk("crlf_on_1", 32'(seen[1]), 32'h0A);
            chk("crlf_on_2", 32'(seen[2]), 32'h58);
        end
        crlf_en = 1'b0;
        seen.delete();
        send(8'h0D);
        send(8'h58);
        wait_idle();
        chk("crlf_off_len", seen.size(), 32'd2);
        if (seen.size() == 2) begin
            chk("crlf_off_0", 32'(seen[0]), 32'h0D);
            chk("crlf_off_1", 32'(seen[1]), 32'h58);
        end

        // Overflow: 18 bytes into a stalled path, one is dropped.
        tx_ready = 1'b0;
        seen.delete();
        for (int i = 0; i < 18; i++) send(8'(i));
        chk("ovf_count", 32'(fifo_count), 32'd16);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_hold", 32'(tx_data), 32'h00);
        chk("ovf_hist", history, 32'h0E0F1011);
        clr_overflow = 1'b1;
        send(8'h12);
        clr_overflow = 1'b0;
        chk("ovf_set_wins", 32'(overflow), 32'd1);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        chk("ovf_cleared", 32'(overflow), 32'd0);
        tx_ready = 1'b1;
        send(8'h20);
        chk("full_push_pop_count", 32'(fifo_count), 32'd16);
        chk("full_push_pop_ovf", 32'(overflow), 32'd0);
        wait_idle();
        chk("ovf_drain_len", seen.size(), 32'd18);
        if (seen.size() == 18) begin
            chk("ovf_drain_first", 32'(seen[0]), 32'h00);
            chk("ovf_drain_16", 32'(seen[16]), 32'h10);
            chk("ovf_drain_last", 32'(seen[17]), 32'h20);
        end

        // echo_en low: history only; queued bytes still drain.
        echo_en = 1'b0;
        send(8'h55);
        tick();
        chk("noecho_hist", 32'(history[7:0]), 32'h55);
        chk("noecho_count", 32'(fifo_count), 32'd0);
        chk("noecho_valid", 32'(tx_valid), 32'd0);
        echo_en = 1'b1;
        tx_ready = 1'b0;
        seen.delete();
        send(8'hA1);
        send(8'hA2);
        send(8'hA3);
        tick();
        chk("noecho_queued", 32'(fifo_count), 32'd2);
        echo_en = 1'b0;
        tx_ready = 1'b1;
        wait_idle();
        chk("noecho_drain_len", seen.size(), 32'd3);
        if (seen.size() == 3) chk("noecho_drain_last", 32'(seen[2]), 32'hA3);

        // Reset while holding a byte on the output.
        echo_en = 1'b1;
        tx_ready = 1'b0;
        send(8'h77);
        send(8'h78);
        tick();
        chk("pre_rst_valid", 32'(tx_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(tx_valid), 32'd0);
        chk("async_rst_data", 32'(tx_data), 32'h00);
        chk("async_rst_hist", history, 32'h0);
        chk("async_rst_count", 32'(fifo_count), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tx_ready = 1'b1;
        seen.delete();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_rst_valid", 32'(tx_valid), 32'd0);
        end
        chk("post_rst_seen", seen.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_echo_buffer.md
Name: uart_echo_buffer

Overview:
Parametrised successor to the fixed 4-byte echo/display path. Sits between uart_rx and uart_tx in the top level. Buffers received bytes in a FIFO so echo survives back-to-back RX traffic, and optionally expands CR to CR LF on the echo. Also keeps an N-byte receive history vector for led_nibble_display, and reports drops through a sticky overflow flag.

Parameters:
DEPTH, 16, echo FIFO depth in bytes; power of two, >= 2
HIST_BYTES, 4, number of most-recent received bytes in the history output; >= 1

Ports:
CLK  in  1  system clock (12 MHz)
rst_n  in  1  asynchronous active-low reset
rx_data  in  8  received byte from uart_rx
rx_valid  in  1  single-cycle strobe; rx_data is valid that cycle
echo_en  in  1  1 = received bytes are queued for echo
crlf_en  in  1  1 = echoed 0x0D is followed by 0x0A
tx_data  out  8  byte offered to uart_tx
tx_valid  out  1  tx_data is valid
tx_ready  in  1  uart_tx can accept; a transfer occurs when tx_valid & tx_ready in the same cycle
history  out  HIST_BYTES*8  last received bytes; newest in [7:0]
fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH
overflow  out  1  sticky: a byte was dropped because the FIFO was full
clr_overflow  in  1  clears overflow

Behaviour:
- Reset (async assert, sync release):
  - tx_valid=0, tx_data=0x00, history=0, fifo_count=0, overflow=0, FSM=IDLE.
  - Reset mid-transfer discards the FIFO contents and any pending LF.
- History:
  - On every rx_valid: history <= {history[HIST_BYTES*8-9:0], rx_data}.
  - Updates regardless of echo_en and FIFO full. For HIST_BYTES=1, history <= rx_data.
- FIFO write:
  - Write when rx_valid & echo_en and the FIFO is not full, or when it is full and a pop happens in the same cycle. In the full-with-pop case, occupancy stays DEPTH.
  - Full with no pop: the byte is dropped and overflow <= 1.
  - echo_en=0: no writes; queued bytes still drain.
- Overflow:
  - Cleared by clr_overflow.
  - If a drop and clr_overflow occur in the same cycle, set wins.
- FIFO pop: occurs only when the FSM loads the output register (see below).
- fifo_count is registered and reflects pushes/pops at the preceding edge.
- TX FSM (states IDLE, SEND, SEND_LF):
  - IDLE: if FIFO non-empty, load head into tx_data, pop, tx_valid<=1, lf_pend<=(head==0x0D)&crlf_en, go SEND.
  - SEND, no handshake: hold tx_data and tx_valid stable.
  - SEND, handshake with lf_pend=1: tx_data<=0x0A, tx_valid stays 1, go SEND_LF.
  - SEND, handshake with lf_pend=0 and FIFO non-empty: load next head and pop (back-to-back, no bubble), stay SEND.
  - SEND, handshake with lf_pend=0 and FIFO empty: tx_valid<=0, go IDLE.
  - SEND_LF, no handshake: hold tx_data and tx_valid stable.
  - SEND_LF, handshake: same continuation as SEND with lf_pend=0.
  - crlf_en is sampled only at load time; changing it later does not affect a byte already loaded.
- Latency:
  - rx_valid at cycle N into an empty FIFO with FSM in IDLE gives tx_valid=1 at cycle N+2, with tx_data = that byte.
  - History shows the byte at cycle N+1.
- tx_data/tx_valid are registered outputs, with no combinational path from tx_ready.
- Throughput: 1 byte per handshake while the FIFO is non-empty. The LF insertion consumes one output slot without popping.

Decomposition:
- Package uart_echo_pkg contains:
  - state enum echo_state_e {IDLE, SEND, SEND_LF}
  - constants ASCII_CR=8'h0D and ASCII_LF=8'h0A
  - localparam helper for the count width
- Sub-module sync_fifo (params WIDTH, DEPTH):
  - ports CLK, rst_n, wr_en, wr_data, rd_en, rd_data (head, show-ahead), full, empty, count
  - simultaneous read/write when full is allowed
- uart_echo_buffer holds the history register, overflow logic and TX FSM.
- Top-level blinky instantiates it with HIST_BYTES=4.

Test Plan:
- Reset: hold rst_n=0 mid-SEND with tx_valid=1 -> tx_valid drops immediately (async), history=0, fifo_count=0; after release, no stale byte is emitted.
- Single echo: tx_ready=1, rx 0x41 at cycle N -> tx_valid=1, tx_data=0x41 at N+2; history[7:0]=0x41 at N+1; then tx_valid=0.
- Back-to-back with backpressure: rx 0x31,0x32,0x33 on consecutive cycles, tx_ready=0 for 10 cycles -> fifo_count=2 with 0x31 held on tx_data; then tx_ready=1 -> 0x31,0x32,0x33 on consecutive cycles, no bubble; history[23:0]=0x313233.
- CRLF: crlf_en=1, rx 0x0D,0x58 -> output sequence 0x0D,0x0A,0x58. Repeat with crlf_en=0 -> 0x0D,0x58 only.
- Overflow: DEPTH=16, tx_ready=0, rx 18 bytes 0x00..0x11 -> fifo_count=16 (byte 0x00 in output register, 0x01..0x10 queued), 0x11 dropped, overflow=1; history[31:0]=0x0E0F1011. Then clr_overflow with a simultaneous drop -> overflow stays 1.
- echo_en=0: rx 0x55 -> history updates, fifo_count stays 0, tx_valid stays 0. Deassert echo_en with 3 bytes queued -> all 3 still drain.
